// File: rtl/arp_resolve_ctrl.sv
// Next-hop resolver in front of the ARP cache: applies broadcast/subnet/gateway
// routing, queries the cache and drives ARP requests with timeout and retry on a miss.
module arp_resolve_ctrl #(
  parameter int REQUEST_TIMEOUT = 1000,
  parameter int RETRY_COUNT     = 3,
  parameter int TIMERW          = $clog2(REQUEST_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask,
  input  logic        in_req_valid,
  input  logic [31:0] in_req_ip,
  output logic        in_req_ready,
  output logic        in_rsp_valid,
  output logic        in_rsp_err,
  output logic [47:0] in_rsp_mac,
  input  logic        in_rsp_ready,
  output logic        cache_query_valid,
  output logic [31:0] cache_query_ip,
  input  logic        cache_query_ready,
  input  logic        cache_rsp_valid,
  input  logic        cache_rsp_err,
  input  logic [47:0] cache_rsp_mac,
  output logic        cache_rsp_ready,
  input  logic        cache_wr_valid,
  input  logic        cache_wr_ready,
  input  logic [31:0] cache_wr_ip,
  output logic        arp_req_valid,
  output logic [31:0] arp_req_ip,
  input  logic        arp_req_ready
);

  localparam int CNTW = $clog2(RETRY_COUNT + 1);
  localparam logic [CNTW-1:0]   RETRY_MAX  = CNTW'(RETRY_COUNT);
  localparam logic [TIMERW-1:0] TIMER_LOAD = TIMERW'(REQUEST_TIMEOUT);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_QUERY      = 3'd1;
  localparam logic [2:0] S_WAIT_RSP   = 3'd2;
  localparam logic [2:0] S_SEND_ARP   = 3'd3;
  localparam logic [2:0] S_WAIT_REPLY = 3'd4;
  localparam logic [2:0] S_RESPOND    = 3'd5;

  logic [2:0]        state_reg, state_next;
  logic [31:0]       target_reg, target_next;
  logic [CNTW-1:0]   sent_cnt_reg, sent_cnt_next;
  logic [TIMERW-1:0] timer_reg, timer_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [47:0]       rsp_mac_reg, rsp_mac_next;
  logic              req_ready_reg;

  logic        is_bcast;
  logic [31:0] route_ip;
  logic        snoop_hit;

  assign is_bcast  = (in_req_ip | subnet_mask) == 32'hFFFF_FFFF;
  assign route_ip  = (((in_req_ip ^ local_ip) & subnet_mask) != 32'd0) ? gateway_ip : in_req_ip;
  assign snoop_hit = cache_wr_valid & cache_wr_ready & (cache_wr_ip == target_reg);

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    sent_cnt_next = sent_cnt_reg;
    timer_next    = timer_reg;
    rsp_err_next  = rsp_err_reg;
    rsp_mac_next  = rsp_mac_reg;
    case (state_reg)
      S_IDLE: begin
        // req_ready_reg gates accept so nothing is taken in the cycle after reset
        if (in_req_valid && req_ready_reg) begin
          sent_cnt_next = '0;
          if (is_bcast) begin
            target_next  = in_req_ip;
            rsp_err_next = 1'b0;
            rsp_mac_next = 48'hFFFF_FFFF_FFFF;
            state_next   = S_RESPOND;
          end else begin
            target_next = route_ip;
            if (route_ip == 32'd0) begin
              rsp_err_next = 1'b1;
              rsp_mac_next = 48'd0;
              state_next   = S_RESPOND;
            end else begin
              state_next = S_QUERY;
            end
          end
        end
      end
      S_QUERY: begin
        if (cache_query_ready) state_next = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (cache_rsp_valid) begin
          if (!cache_rsp_err) begin
            rsp_err_next = 1'b0;
            rsp_mac_next = cache_rsp_mac;
            state_next   = S_RESPOND;
          end else if (sent_cnt_reg == RETRY_MAX) begin
            rsp_err_next = 1'b1;
            rsp_mac_next = 48'd0;
            state_next   = S_RESPOND;
          end else begin
            state_next = S_SEND_ARP;
          end
        end
      end
      S_SEND_ARP: begin
        if (arp_req_ready) begin
          sent_cnt_next = sent_cnt_reg + 1'b1;
          timer_next    = TIMER_LOAD;
          state_next    = S_WAIT_REPLY;
        end
      end
      S_WAIT_REPLY: begin
        timer_next = timer_reg - 1'b1;
        // A matching cache write wins over expiry in the same cycle
        if (snoop_hit) begin
          state_next = S_QUERY;
        end else if (timer_reg == TIMERW'(1)) begin
          if (sent_cnt_reg == RETRY_MAX) begin
            rsp_err_next = 1'b1;
            rsp_mac_next = 48'd0;
            state_next   = S_RESPOND;
          end else begin
            state_next = S_SEND_ARP;
          end
        end
      end
      S_RESPOND: begin
        if (in_rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      target_reg    <= 32'd0;
      sent_cnt_reg  <= '0;
      timer_reg     <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_mac_reg   <= 48'd0;
      req_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      sent_cnt_reg  <= sent_cnt_next;
      timer_reg     <= timer_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_mac_reg   <= rsp_mac_next;
      req_ready_reg <= (state_next == S_IDLE);
    end
  end

  assign in_req_ready      = req_ready_reg;
  assign in_rsp_valid      = (state_reg == S_RESPOND);
  assign in_rsp_err        = rsp_err_reg;
  assign in_rsp_mac        = rsp_mac_reg;
  assign cache_query_valid = (state_reg == S_QUERY);
  assign cache_query_ip    = target_reg;
  assign cache_rsp_ready   = (state_reg == S_WAIT_RSP);
  assign arp_req_valid     = (state_reg == S_SEND_ARP);
  assign arp_req_ip        = target_reg;

endmodule
